// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default widths, MIPS control
// field offsets, the stored entry layout and the occupancy FSM state encoding.
package pipe_pkg;

  localparam int PIPE_DATA_W = 96;
  localparam int PIPE_CTRL_W = 15;

  // Control field offsets within the ctrl vector: {rd[4:0], rt[4:0], regwrite, memtoreg, regdst, spare[1:0]}
  localparam int PIPE_CTRL_REGDST   = 2;
  localparam int PIPE_CTRL_MEMTOREG = 3;
  localparam int PIPE_CTRL_REGWRITE = 4;
  localparam int PIPE_CTRL_RT       = 5;
  localparam int PIPE_CTRL_RD       = 10;

  typedef struct packed {
    logic [PIPE_CTRL_W-1:0] ctrl;
    logic [PIPE_DATA_W-1:0] data;
  } pipe_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage boundary.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 15
);
  // Valid/ready: a transfer happens on a clock edge where valid and ready are both 1.
  // While valid=1 and ready=0 the producer holds data/ctrl stable; ready may depend on
  // registered state and hold only, never on the same side's valid.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with main+skid buffer, hold and flush.
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               flush,
  pipe_stage_reg_if.slave    bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output occ_state_e         occ_state
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  occ_state_e state_q, state_d;
  entry_t     main_q, skid_q, in_entry;
  logic       main_v, skid_v, acc, emit;
  logic       ld_main_in, ld_main_skid, ld_skid;

  assign in_entry = '{ctrl: bus.in_ctrl, data: bus.in_data};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state: flush beats hold beats normal flow
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else if (!hold) begin
      case (state_q)
        OCC_EMPTY: state_d = acc ? OCC_ONE : OCC_EMPTY;
        OCC_ONE: begin
          if (emit) state_d = acc ? OCC_ONE : OCC_EMPTY;
          else      state_d = acc ? OCC_TWO : OCC_ONE;
        end
        OCC_TWO:   state_d = emit ? OCC_ONE : OCC_TWO;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // Outputs and datapath load enables
  always_comb begin
    main_v       = (state_q != OCC_EMPTY);
    skid_v       = (state_q == OCC_TWO);
    bus.in_ready = ~skid_v & ~hold;
    acc          = bus.in_valid & bus.in_ready;
    emit         = main_v & bus.out_ready & ~hold;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (!flush && !hold) begin
      ld_main_in   = acc & ((state_q == OCC_EMPTY) | ((state_q == OCC_ONE) & emit));
      ld_main_skid = (state_q == OCC_TWO) & emit;
      ld_skid      = acc & (state_q == OCC_ONE) & ~emit;
    end
  end

  // Payload registers are not cleared by flush; only the valid state is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_entry;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_entry;
    end
  end

  assign bus.out_valid = main_v;
  assign bus.out_data  = main_q.data;
  assign bus.out_ctrl  = main_q.ctrl;
  assign occ_state     = state_q;

`ifdef PIPE_STAGE_PERF_EN
  // A held stage with a valid entry is stalled regardless of out_ready.
  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (main_v & (~bus.out_ready | hold)),
    .cnt   (stall_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (~main_v),
    .cnt   (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, back-pressure, flush, hold and
// the optional perf counters (PIPE_STAGE_PERF_EN).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 96;
  localparam int CW = 15;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, hold, flush;
  logic [NW-1:0] stall_cnt, bubble_cnt;
  occ_state_e    occ_state;
  int            vec_cnt = 0;
  int            err_cnt = 0;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .flush      (flush),
    .bus        (bus),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .occ_state  (occ_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ctrl  = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst0_valid: got %0b exp 0", bus.out_valid); end
    vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst0_ready: got %0b exp 1", bus.in_ready); end
    vec_cnt++; if (bus.out_data !== '0) begin err_cnt++; $display("FAIL rst0_data: got %0h exp 0", bus.out_data); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Fill main and skid, then reset mid-stream
    drive(1'b1, 96'hA1, 15'h11); step();
    drive(1'b1, 96'hA2, 15'h22); step();
    drive(1'b0, '0, '0);
    vec_cnt++; if (occ_state !== OCC_TWO) begin err_cnt++; $display("FAIL rst_fill_state: got %0d exp %0d", occ_state, OCC_TWO); end
    #2 rst = 1'b1;
    #1;
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_valid: got %0b exp 0", bus.out_valid); end
    vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_ready: got %0b exp 1", bus.in_ready); end
    vec_cnt++; if (bus.out_data !== '0) begin err_cnt++; $display("FAIL rst_mid_data: got %0h exp 0", bus.out_data); end
    vec_cnt++; if (bus.out_ctrl !== '0) begin err_cnt++; $display("FAIL rst_mid_ctrl: got %0h exp 0", bus.out_ctrl); end
    vec_cnt++; if (occ_state !== OCC_EMPTY) begin err_cnt++; $display("FAIL rst_mid_state: got %0d exp 0", occ_state); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), CW'(i + 16));
      step();
      vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL stream_valid_%0d: got %0b exp 1", i, bus.out_valid); end
      vec_cnt++; if (bus.out_data !== DW'(i)) begin err_cnt++; $display("FAIL stream_data_%0d: got %0h exp %0h", i, bus.out_data, i); end
      vec_cnt++; if (bus.out_ctrl !== CW'(i + 16)) begin err_cnt++; $display("FAIL stream_ctrl_%0d: got %0h exp %0h", i, bus.out_ctrl, i + 16); end
      vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL stream_ready_%0d: got %0b exp 1", i, bus.in_ready); end
    end
    drive(1'b0, '0, '0);
    step();
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_drain: got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 96'hA, 15'h0A); step();
    vec_cnt++; if (bus.out_data !== 96'hA) begin err_cnt++; $display("FAIL bp_a_main: got %0h exp a", bus.out_data); end
    vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_a_ready: got %0b exp 1", bus.in_ready); end
    drive(1'b1, 96'hB, 15'h0B); step();
    vec_cnt++; if (bus.out_data !== 96'hA) begin err_cnt++; $display("FAIL bp_b_main: got %0h exp a", bus.out_data); end
    vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_b_ready: got %0b exp 0", bus.in_ready); end
    vec_cnt++; if (occ_state !== OCC_TWO) begin err_cnt++; $display("FAIL bp_b_state: got %0d exp 2", occ_state); end
    // Offered C must not be sampled while full
    drive(1'b1, 96'hC, 15'h0C); step();
    vec_cnt++; if (bus.out_data !== 96'hA) begin err_cnt++; $display("FAIL bp_c_main: got %0h exp a", bus.out_data); end
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    step();
    vec_cnt++; if (bus.out_data !== 96'hB || bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_emit_b: got %0h/%0b exp b/1", bus.out_data, bus.out_valid); end
    vec_cnt++; if (bus.out_ctrl !== 15'h0B) begin err_cnt++; $display("FAIL bp_emit_b_ctrl: got %0h exp b", bus.out_ctrl); end
    vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_back: got %0b exp 1", bus.in_ready); end
    step();
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_empty: got %0b exp 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 96'hA, 15'h0A); step();
    drive(1'b1, 96'hB, 15'h0B); step();
    drive(1'b1, 96'hC, 15'h0C);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_two_valid: got %0b exp 0", bus.out_valid); end
    vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_two_ready: got %0b exp 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_ghost_%0d: got %0b exp 0", i, bus.out_valid); end
    end
    // Flush in ONE drops the entry accepted in the same cycle
    bus.out_ready = 1'b0;
    drive(1'b1, 96'hD, 15'h0D); step();
    drive(1'b1, 96'hE, 15'h0E);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_one_valid: got %0b exp 0", bus.out_valid); end
    vec_cnt++; if (occ_state !== OCC_EMPTY) begin err_cnt++; $display("FAIL flush_one_state: got %0d exp 0", occ_state); end
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    drive(1'b1, 96'hD0, 15'h1D); step();
    drive(1'b1, 96'hE0, 15'h1E);
    hold = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL hold_ready_comb: got %0b exp 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 96'hD0) begin err_cnt++; $display("FAIL hold_keep_%0d: got %0b/%0h exp 1/d0", i, bus.out_valid, bus.out_data); end
      vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL hold_ready_%0d: got %0b exp 0", i, bus.in_ready); end
    end
    hold = 1'b0;
    drive(1'b0, '0, '0);
    step();
    vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL hold_release: got %0b exp 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_perf();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b1, 96'hF, 15'h0F);
    #1;
    vec_cnt++; if (stall_cnt !== '0 || bubble_cnt !== '0) begin err_cnt++; $display("FAIL perf_rst: got %0d/%0d exp 0/0", stall_cnt, bubble_cnt); end
    rst = 1'b0;
    step();
    drive(1'b0, '0, '0);
    repeat (20) step();
`ifdef PIPE_STAGE_PERF_EN
    vec_cnt++; if (stall_cnt !== 4'd15) begin err_cnt++; $display("FAIL perf_stall_sat: got %0d exp 15", stall_cnt); end
    vec_cnt++; if (bubble_cnt !== 4'd1) begin err_cnt++; $display("FAIL perf_bubble: got %0d exp 1", bubble_cnt); end
`else
    vec_cnt++; if (stall_cnt !== '0) begin err_cnt++; $display("FAIL perf_stall_tied: got %0d exp 0", stall_cnt); end
    vec_cnt++; if (bubble_cnt !== '0) begin err_cnt++; $display("FAIL perf_bubble_tied: got %0d exp 0", bubble_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_hold();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
